// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: size encoding, FSM states, size-to-bytes helper.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } lsu_size_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ACC0 = 2'b01,
        ACC1 = 2'b10,
        DONE = 2'b11
    } lsu_state_e;

    function automatic logic [2:0] size_nbytes(input lsu_size_e size);
        case (size)
            SZ_BYTE: return 3'd1;
            SZ_HALF: return 3'd2;
            SZ_WORD: return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store merge into the current memory word and load extraction/extension
// from a two-word window (low word = first access, high word = second access).
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  off,
    input  lsu_size_e   size,
    input  logic        is_unsigned,
    input  logic        hi,
    input  logic [31:0] wdata,
    input  logic [31:0] mem_rdata,
    input  logic [63:0] lwin,
    output logic [31:0] merged,
    output logic [31:0] ldata
);

    logic [63:0] sdata;
    logic [7:0]  base_mask;
    logic [7:0]  smask;
    logic [31:0] word_data;
    logic [3:0]  word_mask;
    logic [63:0] lshift;
    logic [31:0] raw;

    always_comb begin
        sdata     = {32'd0, wdata} << {off, 3'b000};
        base_mask = (8'd1 << size_nbytes(size)) - 8'd1;
        smask     = base_mask << off;
        word_data = hi ? sdata[63:32] : sdata[31:0];
        word_mask = hi ? smask[7:4] : smask[3:0];
        merged    = mem_rdata;
        for (int i = 0; i < 4; i++) begin
            if (word_mask[i]) merged[8*i +: 8] = word_data[8*i +: 8];
        end

        lshift = lwin >> {off, 3'b000};
        raw    = lshift[31:0];
        case (size)
            SZ_BYTE: ldata = is_unsigned ? {24'd0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
            SZ_HALF: ldata = is_unsigned ? {16'd0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
            default: ldata = raw;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller over a word-wide combinational-read memory.
// Define LSU_MISALIGN_EN to split misaligned half/word accesses over two words (otherwise they error).
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int MEM_BYTES = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    input  logic [31:0] mem_rdata
);

    lsu_state_e  state, state_nxt;
    lsu_size_e   req_sz, size_q;
    logic        we_q, uns_q, err_q;
    logic [31:0] addr_q, wdata_q;
    logic [63:0] lwin_q;
    logic [2:0]  req_nb;
    logic [32:0] last_byte;
    logic        misalign, req_err, split, hi;
    logic [31:0] merged, ldata;

    assign req_sz    = lsu_size_e'(req_size);
    assign req_nb    = size_nbytes(req_sz);
    // 33-bit sum so an address near 2^32 cannot wrap back into range
    assign last_byte = {1'b0, req_addr} + 33'(req_nb) - 33'd1;

`ifdef LSU_MISALIGN_EN
    assign misalign = 1'b0;
`else
    assign misalign = (req_sz == SZ_HALF && req_addr[0]) ||
                      (req_sz == SZ_WORD && req_addr[1:0] != 2'b00);
`endif

    assign req_err = (req_sz == SZ_RSVD) || (last_byte >= 33'(MEM_BYTES)) || misalign;
    assign split   = (4'(addr_q[1:0]) + 4'(size_nbytes(size_q))) > 4'd4;
    assign hi      = (state == ACC1);

    lsu_align u_align (
        .off        (addr_q[1:0]),
        .size       (size_q),
        .is_unsigned(uns_q),
        .hi         (hi),
        .wdata      (wdata_q),
        .mem_rdata  (mem_rdata),
        .lwin       (lwin_q),
        .merged     (merged),
        .ldata      (ldata)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
            size_q  <= SZ_BYTE;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            lwin_q  <= 64'd0;
        end else begin
            if (state == IDLE && req_valid) begin
                we_q    <= req_we;
                uns_q   <= req_unsigned;
                err_q   <= req_err;
                size_q  <= req_sz;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (state == ACC0) lwin_q[31:0]  <= mem_rdata;
            if (state == ACC1) lwin_q[63:32] <= mem_rdata;
        end
    end

    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        resp_rdata = 32'd0;
        mem_addr   = 32'd0;
        mem_wdata  = 32'd0;
        mem_we     = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = req_err ? DONE : ACC0;
            end
            ACC0: begin
                mem_addr  = {addr_q[31:2], 2'b00};
                mem_we    = we_q;
                mem_wdata = we_q ? merged : 32'd0;
                state_nxt = split ? ACC1 : DONE;
            end
            ACC1: begin
                mem_addr  = {addr_q[31:2], 2'b00} + 32'd4;
                mem_we    = we_q;
                mem_wdata = we_q ? merged : 32'd0;
                state_nxt = DONE;
            end
            DONE: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
                resp_rdata = (we_q || err_q) ? 32'd0 : ldata;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // a reset edge abandons the access, so the pending write must not land on it
        if (!rst_n) mem_we = 1'b0;
    end

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 256, meaning the size in bytes of the word memory behind the block (a multiple of 4).
REQ-002 SHALL have port clk, input, 1 bit: clock, all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-004 SHALL have port req_valid, input, 1 bit: a request is presented.
REQ-005 SHALL have port req_ready, output, 1 bit: the block can accept a request.
REQ-006 SHALL have port req_we, input, 1 bit: 1 = store, 0 = load.
REQ-007 SHALL have port req_size, input, 2 bits: 00 byte, 01 half, 10 word, 11 reserved.
REQ-008 SHALL have port req_unsigned, input, 1 bit: zero-extend load data instead of sign-extending it.
REQ-009 SHALL have port req_addr, input, 32 bits: byte address.
REQ-010 SHALL have port req_wdata, input, 32 bits: store data, right-aligned.
REQ-011 SHALL have port resp_valid, output, 1 bit: one-cycle completion pulse.
REQ-012 SHALL have port resp_rdata, output, 32 bits: extended load data.
REQ-013 SHALL have port resp_err, output, 1 bit: the request was rejected (valid together with resp_valid).
REQ-014 SHALL have port mem_addr, output, 32 bits: word-aligned byte address, with bits [1:0] always 0.
REQ-015 SHALL have port mem_wdata, output, 32 bits: full word to write.
REQ-016 SHALL have port mem_we, output, 1 bit: word write enable; the memory writes on the next rising edge.
REQ-017 SHALL have port mem_rdata, input, 32 bits: combinational read of the word at mem_addr.

Function
REQ-018 SHALL implement the FSM states IDLE, ACC0, ACC1 and DONE.
REQ-019 SHALL drive req_ready=1 only in IDLE.
REQ-020 SHALL accept a request on an edge where req_valid and req_ready are both 1, latching we, size, unsigned, addr and wdata, and SHALL go to ACC0, or go directly to DONE with err=1 when an error condition holds.
REQ-021 SHALL treat any of these as an error condition: size=11; last byte address (addr+nbytes-1, computed at 33 bits with no wrap) >= MEM_BYTES; a misaligned access when LSU_MISALIGN_EN is undefined.
REQ-022 In ACC0, SHALL set mem_addr={addr[31:2],2'b00}; a load captures mem_rdata; a store drives mem_we=1 with mem_wdata equal to mem_rdata with only the addressed byte lanes replaced (read-modify-write in one cycle).
REQ-023 SHALL go from ACC0 to ACC1 when the access crosses a word boundary (addr[1:0]+nbytes>4); otherwise it SHALL go to DONE.
REQ-024 In ACC1, SHALL set mem_addr = word0+4 and perform the same capture or merge for the remaining upper bytes, then go to DONE.
REQ-025 In DONE, SHALL drive resp_valid=1 for exactly one cycle, with resp_rdata holding the assembled bytes extended per size and unsigned, then return to IDLE.
REQ-026 SHALL drive resp_rdata=0 on a store or an error.
REQ-027 Latency from the accept edge to resp_valid: SHALL be 2 cycles for a single-word access, 3 cycles for a split access, and 1 cycle for an error.
REQ-028 SHALL drive mem_we=0 outside ACC0 and ACC1, and SHALL never assert it for an erroneous request.
REQ-029 SHALL hold mem_addr at 0 in IDLE and DONE.
REQ-030 SHALL ignore req_valid while req_ready=0, with no queuing.

Reset
REQ-031 When rst_n=0 at an edge, SHALL enter IDLE regardless of state, abandoning any access; req_ready SHALL be 1 and resp_valid, resp_err, mem_we, resp_rdata and mem_addr SHALL be 0 from the next cycle.
REQ-032 SHALL NOT complete the second word of an interrupted split store.

Configuration
REQ-033 SHALL recognise the macro LSU_MISALIGN_EN.
REQ-034 When LSU_MISALIGN_EN is defined, SHALL split misaligned half and word accesses into two word accesses via ACC1.
REQ-035 When LSU_MISALIGN_EN is undefined, SHALL report a half access with addr[0]!=0 or a word access with addr[1:0]!=0 as an error; ACC1 is then unreachable and may be optimised away.

Structure
REQ-036 SHALL take the size encoding, the FSM state enum and a function returning nbytes from size from shared package lsu_pkg.
REQ-037 SHALL use one combinational sub-module, lsu_align, for lane shifting, store merge and load sign/zero extension.

Verification
REQ-038 SHALL cover: memory word 0x04 = 0x8899AABB, LB addr 0x06 -> resp_rdata 0xFFFFFF99, resp_err=0, resp_valid 2 cycles after accept.
REQ-039 SHALL cover: SB 0x5A to addr 0x05 over word 0x04 = 0x11223344 -> one mem_we cycle, memory word 0x04 = 0x11225A44.
REQ-040 SHALL cover (LSU_MISALIGN_EN defined): word 0x00 = 0x44332211 and word 0x04 = 0x88776655, LW addr 0x02 -> 0x66554433 after 3 cycles; SH 0xBEEF to 0x03 -> word 0x00 = 0xEF332211, word 0x04 = 0x887766BE.
REQ-041 SHALL cover (LSU_MISALIGN_EN undefined): LW addr 0x02 -> resp_err=1 after 1 cycle, no mem_we, memory unchanged.
REQ-042 SHALL cover bounds: MEM_BYTES=256, LW addr 0xFC -> OK; LH addr 0xFF -> err; req_size=11 -> err; addr 0xFFFFFFFE -> err with no wrap.
REQ-043 SHALL cover: rst_n=0 during ACC1 of a split store -> IDLE next cycle, only the first word written, resp_valid never asserted.
